// File: rtl/fifo_pkg.sv
// Shared sizing for the word FIFO behind the 8-to-32 byte packer.
package fifo_pkg;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int AF_TH  = 6;
    localparam int AE_TH  = 2;
    localparam int CNT_W  = ADDR_W + 1;
endpackage

// File: rtl/mem_2p.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module mem_2p
    import fifo_pkg::*;
(
    input  logic              clk_f,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; stale words are unreachable until rewritten.
    always_ff @(posedge clk_f) begin
        if (we) mem[waddr] <= wdata;
    end

    // A same-edge write to raddr is not visible here: the read returns the old word.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_32.sv
// Word FIFO in the clk_f domain: absorbs consumer stalls after the byte packer,
// reports occupancy, threshold flags and a sticky overflow/underflow error.
module fifo_32
    import fifo_pkg::*;
(
    input  logic              clk_f,
    input  logic              reset,
    input  logic              in32,
    input  logic [DATA_W-1:0] in_data32,
    input  logic              pop,
    output logic [DATA_W-1:0] out_data32,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // No fall-through: pop against an empty FIFO is refused even if a push lands now.
    assign rd_ok = pop & ~empty;
    assign wr_ok = in32 & (~full | rd_ok);

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_TH));
    assign almost_empty = (count <= CNT_W'(AE_TH));

    mem_2p u_mem (
        .clk_f (clk_f),
        .reset (reset),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (in_data32),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (out_data32)
    );

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid_out <= rd_ok;
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if ((in32 & full & ~rd_ok) | (pop & empty)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_32.sv
// Directed and randomized checks of fifo_32 against a queue-based reference.
module tb_fifo_32;

    logic        clk_f = 1'b0;
    logic        reset = 1'b1;
    logic        in32 = 1'b0;
    logic [31:0] in_data32 = '0;
    logic        pop = 1'b0;
    logic [31:0] out_data32;
    logic        valid_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q[$];
    logic        m_err   = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_out   = '0;

    fifo_32 dut (
        .clk_f        (clk_f),
        .reset        (reset),
        .in32         (in32),
        .in_data32    (in_data32),
        .pop          (pop),
        .out_data32   (out_data32),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err          (err)
    );

    always #10 clk_f = ~clk_f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"},        32'(count),        32'(sz));
        chk({tag, ".full"},         32'(full),         32'(sz == 8));
        chk({tag, ".empty"},        32'(empty),        32'(sz == 0));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(sz >= 6));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= 2));
        chk({tag, ".err"},          32'(err),          32'(m_err));
        chk({tag, ".valid_out"},    32'(valid_out),    32'(m_valid));
        chk({tag, ".out_data32"},   out_data32,        m_out);
    endtask

    // Called at a falling edge; drives one cycle and checks at the next falling edge.
    task automatic step(input string tag, input logic w, input logic [31:0] d, input logic p);
        bit was_full, was_empty, r_acc, w_acc;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        r_acc = p && !was_empty;
        w_acc = w && (!was_full || r_acc);
        if ((w && was_full && !r_acc) || (p && was_empty)) m_err = 1'b1;
        m_valid = r_acc;
        if (r_acc) m_out = q.pop_front();
        if (w_acc) q.push_back(d);
        in32 = w; in_data32 = d; pop = p;
        @(posedge clk_f);
        @(negedge clk_f);
        in32 = 1'b0; pop = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #5 reset = 1'b0;
        q.delete();
        m_err = 1'b0; m_valid = 1'b0; m_out = '0;
        @(negedge clk_f);
    endtask

    initial begin
        logic [31:0] words [3];
        int pw, pp, ph;
        words[0] = 32'h0003_0D0F;
        words[1] = 32'h1122_3344;
        words[2] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk_f);
        reset = 1'b0;
        @(negedge clk_f);
        check_all("por");

        // 1: asynchronous reset between edges while holding words
        for (int i = 0; i < 3; i++) step("t1_push", 1'b1, 32'h100 + 32'(i), 1'b0);
        #2 reset = 1'b1;
        #2;
        chk("t1_async.count", 32'(count), 32'd0);
        chk("t1_async.empty", 32'(empty), 32'd1);
        chk("t1_async.err", 32'(err), 32'd0);
        chk("t1_async.valid_out", 32'(valid_out), 32'd0);
        #3 reset = 1'b0;
        q.delete(); m_err = 1'b0; m_valid = 1'b0; m_out = '0;
        @(negedge clk_f);
        check_all("t1_after");

        // 2: packer stream then three pops
        for (int i = 0; i < 3; i++) step("t2_push", 1'b1, words[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("t2_pop", 1'b0, '0, 1'b1);
            chk("t2_word", out_data32, words[i]);
            chk("t2_valid", 32'(valid_out), 32'd1);
        end
        chk("t2_empty_end", 32'(empty), 32'd1);

        // 3: fill to full, then overflow
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step("t3_fill", 1'b1, 32'h300 + 32'(i), 1'b0);
            chk("t3_af", 32'(almost_full), 32'(i + 1 >= 6));
        end
        chk("t3_full", 32'(full), 32'd1);
        step("t3_ovf", 1'b1, 32'hBAD0_BAD0, 1'b0);
        chk("t3_ovf_err", 32'(err), 32'd1);
        chk("t3_ovf_count", 32'(count), 32'd8);

        // 4: push and pop together at full, then drain across the wrap
        do_reset();
        for (int i = 0; i < 8; i++) step("t4_fill", 1'b1, 32'h400 + 32'(i), 1'b0);
        step("t4_pushpop", 1'b1, 32'hA5A5_A5A5, 1'b1);
        chk("t4_count", 32'(count), 32'd8);
        chk("t4_err", 32'(err), 32'd0);
        chk("t4_first", out_data32, 32'h400);
        for (int i = 0; i < 8; i++) step("t4_drain", 1'b0, '0, 1'b1);
        chk("t4_last", out_data32, 32'hA5A5_A5A5);
        chk("t4_empty", 32'(empty), 32'd1);

        // 5: push and pop while empty
        do_reset();
        step("t5_both", 1'b1, 32'h5555_0001, 1'b1);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_valid", 32'(valid_out), 32'd0);
        chk("t5_count", 32'(count), 32'd1);
        step("t5_pop", 1'b0, '0, 1'b1);
        chk("t5_word", out_data32, 32'h5555_0001);

        // 6: random traffic in phases biased toward fill, drain and balance
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            ph = (i / 200) % 3;
            pw = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
            pp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
            step("t6_rand",
                 logic'($urandom_range(99) < 32'(pw)),
                 $urandom,
                 logic'($urandom_range(99) < 32'(pp)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
